// File: rtl/fb_rect_writer_pkg.sv
// Shared types and constants for the frame-buffer rectangle writer.
// Contents: screen geometry, RGB332 pixel type, command record, engine state enum and
// the row-base helper used once per command.
package fb_pkg;

  localparam int unsigned H_RES     = 640;
  localparam int unsigned V_RES     = 480;
  localparam int unsigned FB_ADDR_W = 19;
  localparam int unsigned COLOR_W   = 8;
  localparam int unsigned CRD_W     = 10;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef struct packed {
    logic [CRD_W-1:0] x0;
    logic [CRD_W-1:0] y0;
    logic [CRD_W-1:0] w;
    logic [CRD_W-1:0] h;
    rgb332_t          color;
    logic             outline;
  } fb_cmd_t;

  typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} fb_wr_state_t;

  // Start address of line y; only evaluated when a command is loaded.
  function automatic logic [FB_ADDR_W-1:0] row_base_of(logic [CRD_W-1:0] y);
    return FB_ADDR_W'(y) * FB_ADDR_W'(H_RES);
  endfunction

endpackage

// File: rtl/fb_rect_writer_if.sv
// Bus bundle of the rectangle writer: command handshake, abort, frame-buffer write
// port and status. master = draw logic / arbiter side, slave = the engine.
interface fb_rect_writer_if;
  import fb_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [CRD_W-1:0]     cmd_x0;
  logic [CRD_W-1:0]     cmd_y0;
  logic [CRD_W-1:0]     cmd_w;
  logic [CRD_W-1:0]     cmd_h;
  logic [COLOR_W-1:0]   cmd_color;
  logic                 cmd_outline;
  logic                 abort;
  logic [FB_ADDR_W-1:0] write_address;
  logic [COLOR_W-1:0]   write_data;
  logic                 write_en;
  logic                 wr_ready;
  logic                 busy;
  logic                 done;

  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, cmd_outline, abort, wr_ready,
    input  cmd_ready, write_address, write_data, write_en, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, cmd_outline, abort, wr_ready,
    output cmd_ready, write_address, write_data, write_en, busy, done
  );

endinterface

// File: rtl/fb_raster_counter.sv
// Raster walker for one clipped rectangle. Holds x/y, the current row base and the
// registered write address; no per-pixel multiply.
// Ports: i_load (start at x0,y0), i_advance (current pixel accepted), i_outline
// (skip interior pixels), i_x0/i_y0/i_x_end/i_y_end (held bounds, end exclusive),
// o_addr (address of current pixel), o_last (current pixel is the final one).
module fb_raster_counter
  import fb_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load,
  input  logic                 i_advance,
  input  logic                 i_outline,
  input  logic [CRD_W-1:0]     i_x0,
  input  logic [CRD_W-1:0]     i_y0,
  input  logic [CRD_W-1:0]     i_x_end,
  input  logic [CRD_W-1:0]     i_y_end,
  output logic [FB_ADDR_W-1:0] o_addr,
  output logic                 o_last
);

  logic [CRD_W-1:0]     r_x, r_y;
  logic [FB_ADDR_W-1:0] r_row_base, r_addr;
  logic                 w_x_last, w_y_last, w_skip;
  logic [CRD_W-1:0]     w_x_right;
  logic [FB_ADDR_W-1:0] w_load_base, w_next_base;

  assign w_x_right   = i_x_end - 1'b1;
  assign w_x_last    = (r_x == w_x_right);
  assign w_y_last    = (r_y == i_y_end - 1'b1);
  // Interior rows of an outline only touch the two side columns.
  assign w_skip      = i_outline && (r_y != i_y0) && !w_y_last && (r_x == i_x0);
  assign w_load_base = row_base_of(i_y0);
  assign w_next_base = r_row_base + FB_ADDR_W'(H_RES);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
      r_addr     <= '0;
    end else if (i_load) begin
      r_x        <= i_x0;
      r_y        <= i_y0;
      r_row_base <= w_load_base;
      r_addr     <= w_load_base + FB_ADDR_W'(i_x0);
    end else if (i_advance) begin
      if (w_x_last) begin
        r_x        <= i_x0;
        r_y        <= r_y + 1'b1;
        r_row_base <= w_next_base;
        r_addr     <= w_next_base + FB_ADDR_W'(i_x0);
      end else if (w_skip) begin
        r_x    <= w_x_right;
        r_addr <= r_row_base + FB_ADDR_W'(w_x_right);
      end else begin
        r_x    <= r_x + 1'b1;
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  assign o_addr = r_addr;
  assign o_last = w_x_last && w_y_last;

endmodule

// File: rtl/fb_rect_writer.sv
// Frame-buffer rectangle fill engine: takes one command, clips it to 640x480 and
// streams RGB332 writes in raster order (address = x + y*640), stalled by wr_ready.
// Ports: i_clk, i_rst_n (async active-low), io_bus (slave modport of
// fb_rect_writer_if: command handshake, abort, write port, busy/done).
// Optional: define FB_OUTLINE_EN to honour cmd_outline (perimeter-only fill).
module fb_rect_writer
  import fb_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  fb_rect_writer_if.slave   io_bus
);

`ifdef FB_OUTLINE_EN
  localparam bit OutlineEn = 1'b1;
`else
  localparam bit OutlineEn = 1'b0;
`endif

  localparam logic [CRD_W:0] HResSum = H_RES[CRD_W:0];
  localparam logic [CRD_W:0] VResSum = V_RES[CRD_W:0];

  fb_wr_state_t         r_state;
  fb_cmd_t              r_cmd;
  logic [CRD_W-1:0]     r_x_end, r_y_end;
  logic                 r_write_en, r_done, r_busy;

  logic [CRD_W:0]       w_x_sum, w_y_sum;
  logic [CRD_W-1:0]     w_x_end, w_y_end;
  logic                 w_empty, w_load, w_advance, w_last;
  logic [FB_ADDR_W-1:0] w_addr;

  // 11-bit sums so an oversize rectangle clips instead of wrapping.
  always_comb begin
    w_x_sum = {1'b0, r_cmd.x0} + {1'b0, r_cmd.w};
    w_y_sum = {1'b0, r_cmd.y0} + {1'b0, r_cmd.h};
    w_x_end = (w_x_sum > HResSum) ? HResSum[CRD_W-1:0] : w_x_sum[CRD_W-1:0];
    w_y_end = (w_y_sum > VResSum) ? VResSum[CRD_W-1:0] : w_y_sum[CRD_W-1:0];
    w_empty = (r_cmd.w == '0) || (r_cmd.h == '0) ||
              ({1'b0, r_cmd.x0} >= HResSum) || ({1'b0, r_cmd.y0} >= VResSum);
  end

  assign w_load    = (r_state == CLIP) && !io_bus.abort && !w_empty;
  assign w_advance = (r_state == FILL) && io_bus.wr_ready && !io_bus.abort;

  fb_raster_counter u_raster (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_load),
    .i_advance (w_advance),
    .i_outline (r_cmd.outline),
    .i_x0      (r_cmd.x0),
    .i_y0      (r_cmd.y0),
    .i_x_end   (r_x_end),
    .i_y_end   (r_y_end),
    .o_addr    (w_addr),
    .o_last    (w_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cmd      <= '0;
      r_x_end    <= '0;
      r_y_end    <= '0;
      r_write_en <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (io_bus.cmd_valid) begin
            r_cmd.x0      <= io_bus.cmd_x0;
            r_cmd.y0      <= io_bus.cmd_y0;
            r_cmd.w       <= io_bus.cmd_w;
            r_cmd.h       <= io_bus.cmd_h;
            r_cmd.color   <= rgb332_t'(io_bus.cmd_color);
            r_cmd.outline <= io_bus.cmd_outline & OutlineEn;
            r_busy        <= 1'b1;
            r_state       <= CLIP;
          end
        end
        CLIP: begin
          r_x_end <= w_x_end;
          r_y_end <= w_y_end;
          if (io_bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_empty) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_write_en <= 1'b1;
            r_state    <= FILL;
          end
        end
        FILL: begin
          if (io_bus.abort) begin
            r_write_en <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end else if (io_bus.wr_ready && w_last) begin
            r_write_en <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.cmd_ready     = (r_state == IDLE);
  assign io_bus.write_address = w_addr;
  assign io_bus.write_data    = r_cmd.color;
  assign io_bus.write_en      = r_write_en;
  assign io_bus.busy          = r_busy;
  assign io_bus.done          = r_done;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Scoreboard bench for fb_rect_writer: stimulus pushes expected writes/done events,
// a negedge monitor pops and compares them against the write port.
module tb_fb_rect_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fb_rect_writer_if io();

  fb_rect_writer dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (io)
  );

  typedef struct {
    bit is_done;
    bit rel_empty;  // done timed from accept (empty command) rather than last write
    int addr;
    int data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ncyc     = 0;
  int   acc_cyc  = 0;
  int   last_wr  = 0;
  bit   first_pend = 0;
  bit   done_prev  = 0;
  bit   bp_mode    = 0;
  int   bp_idx     = 0;
  bit [3:0] bp_pat = 4'b1001;  // wr_ready sequence 1,0,0,1 (LSB first)

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic push_wr(input int addr, input int data);
    exp_t e;
    e.is_done = 0; e.rel_empty = 0; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  task automatic push_done(input bit rel_empty);
    exp_t e;
    e.is_done = 1; e.rel_empty = rel_empty; e.addr = 0; e.data = 0;
    sb.push_back(e);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      first_pend = 0;
      done_prev  = 0;
    end else begin
      if (done_prev) check(io.cmd_ready == 1'b1, "ready_after_done", int'(io.cmd_ready), 1);
      done_prev = io.done;
      if (io.cmd_valid && io.cmd_ready) begin
        acc_cyc    = ncyc;
        first_pend = 1;
      end
      if (io.write_en && !io.abort) begin
        if (first_pend) begin
          check(ncyc == acc_cyc + 2, "first_write_latency", ncyc - acc_cyc, 2);
          first_pend = 0;
        end
        if (sb.size() == 0 || sb[0].is_done) begin
          check(0, "unexpected_write", int'(io.write_address), -1);
        end else begin
          // Compared every write_en cycle, so stalled cycles must hold the same pixel.
          check(int'(io.write_address) == sb[0].addr, "write_address",
                int'(io.write_address), sb[0].addr);
          check(int'(io.write_data) == sb[0].data, "write_data",
                int'(io.write_data), sb[0].data);
          if (io.wr_ready) begin
            void'(sb.pop_front());
            last_wr = ncyc;
          end
        end
      end
      if (io.done) begin
        if (sb.size() == 0 || !sb[0].is_done) begin
          check(0, "unexpected_done", sb.size(), 0);
        end else begin
          if (sb[0].rel_empty)
            check(ncyc == acc_cyc + 2, "done_latency_empty", ncyc - acc_cyc, 2);
          else
            check(ncyc == last_wr + 1, "done_latency", ncyc - last_wr, 1);
          void'(sb.pop_front());
        end
        first_pend = 0;
      end
    end
  end

  // wr_ready driver
  initial begin
    io.wr_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_mode) begin
        io.wr_ready = bp_pat[bp_idx % 4];
        bp_idx++;
      end else begin
        io.wr_ready = 1'b1;
      end
    end
  end

  task automatic issue(input int x0, input int y0, input int w, input int h,
                       input int color, input bit outl);
    bit ok;
    @(posedge clk); #1;
    io.cmd_x0      = 10'(x0);
    io.cmd_y0      = 10'(y0);
    io.cmd_w       = 10'(w);
    io.cmd_h       = 10'(h);
    io.cmd_color   = 8'(color);
    io.cmd_outline = outl;
    io.cmd_valid   = 1'b1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (io.cmd_ready) begin
        ok = 1;
        break;
      end
    end
    check(ok, "cmd_accept", int'(ok), 1);
    @(posedge clk); #1;
    io.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !io.busy) begin
        ok = 1;
        break;
      end
    end
    check(ok, name, sb.size(), 0);
  endtask

  task automatic wait_writes(input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 300 && cnt < n; i++) begin
      @(negedge clk);
      if (io.write_en && io.wr_ready) cnt++;
    end
    check(cnt == n, "writes_before_cut", cnt, n);
  endtask

  initial begin
    int basic_a[6];
    basic_a = '{3210, 3211, 3212, 3850, 3851, 3852};
    io.cmd_valid = 1'b0; io.cmd_x0 = '0; io.cmd_y0 = '0; io.cmd_w = '0; io.cmd_h = '0;
    io.cmd_color = '0; io.cmd_outline = 1'b0; io.abort = 1'b0;

    #1;
    check(io.write_en == 1'b0, "rst_write_en", int'(io.write_en), 0);
    check(io.write_address == '0, "rst_write_address", int'(io.write_address), 0);
    check(io.write_data == '0, "rst_write_data", int'(io.write_data), 0);
    check(io.done == 1'b0, "rst_done", int'(io.done), 0);
    check(io.busy == 1'b0, "rst_busy", int'(io.busy), 0);
    check(io.cmd_ready == 1'b1, "rst_cmd_ready", int'(io.cmd_ready), 1);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // Basic fill
    foreach (basic_a[i]) push_wr(basic_a[i], 'hE0);
    push_done(0);
    issue(10, 5, 3, 2, 'hE0, 0);
    wait_idle("basic_complete");

    // Clipping at bottom-right corner
    push_wr(307198, 'h5A); push_wr(307199, 'h5A); push_done(0);
    issue(638, 479, 5, 4, 'h5A, 0);
    wait_idle("clip_complete");

    // Empty commands
    push_done(1);
    issue(700, 0, 4, 4, 'hFF, 0);
    wait_idle("empty_x_complete");
    push_done(1);
    issue(3, 3, 0, 4, 'hFF, 0);
    wait_idle("empty_w_complete");

    // Back-pressure
    bp_mode = 1; bp_idx = 0;
    foreach (basic_a[i]) push_wr(basic_a[i], 'h1F);
    push_done(0);
    issue(10, 5, 3, 2, 'h1F, 0);
    wait_idle("backpressure_complete");
    bp_mode = 0;

    // Abort after 20 writes
    for (int i = 0; i < 20; i++) push_wr(i, 'h1C);
    issue(0, 0, 100, 1, 'h1C, 0);
    wait_writes(20);
    @(posedge clk); #1 io.abort = 1'b1;
    @(posedge clk); #1 io.abort = 1'b0;
    @(negedge clk);
    check(io.write_en == 1'b0, "abort_write_en", int'(io.write_en), 0);
    check(io.busy == 1'b0, "abort_busy", int'(io.busy), 0);
    check(io.cmd_ready == 1'b1, "abort_idle", int'(io.cmd_ready), 1);
    repeat (5) @(negedge clk);
    check(sb.size() == 0, "abort_write_count", sb.size(), 0);

    // Reset after 20 writes
    for (int i = 0; i < 20; i++) push_wr(i, 'h03);
    issue(0, 0, 100, 1, 'h03, 0);
    wait_writes(20);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check(io.write_en == 1'b0, "reset_write_en", int'(io.write_en), 0);
    check(io.write_address == '0, "reset_write_address", int'(io.write_address), 0);
    check(io.write_data == '0, "reset_write_data", int'(io.write_data), 0);
    check(io.busy == 1'b0, "reset_busy", int'(io.busy), 0);
    check(io.done == 1'b0, "reset_done", int'(io.done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check(sb.size() == 0, "reset_write_count", sb.size(), 0);

    // Outline command
`ifdef FB_OUTLINE_EN
    begin
      int ol_a[10];
      ol_a = '{0, 1, 2, 3, 640, 643, 1280, 1281, 1282, 1283};
      foreach (ol_a[i]) push_wr(ol_a[i], 'hAA);
    end
`else
    begin
      int full_a[12];
      full_a = '{0, 1, 2, 3, 640, 641, 642, 643, 1280, 1281, 1282, 1283};
      foreach (full_a[i]) push_wr(full_a[i], 'hAA);
    end
`endif
    push_done(0);
    issue(0, 0, 4, 3, 'hAA, 1);
    wait_idle("outline_complete");

    repeat (3) @(negedge clk);
    check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fb_rect_writer.md
Name: fb_rect_writer

Overview:
- Frame-buffer write engine. Accepts one rectangle-fill command at a time and streams RGB332 pixel writes into the 640x480 frame buffer in raster order.
- Address mapping is x + y*640, the same mapping the VGA color mapper uses when it reads the buffer back out.
- Sits between the game/draw logic and the frame-buffer SRAM write port. A memory arbiter stalls it through wr_ready.

Parameters:
- H_RES, 640, visible pixels per line and address row stride.
- V_RES, 480, visible lines.
- ADDR_W, 19, frame-buffer address width.
- COLOR_W, 8, pixel width (RGB332: R[7:5], G[4:2], B[1:0]).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine can accept a command.
- cmd_x0  in  10  rectangle left edge.
- cmd_y0  in  10  rectangle top edge.
- cmd_w  in  10  width in pixels.
- cmd_h  in  10  height in pixels.
- cmd_color  in  COLOR_W  fill color.
- cmd_outline  in  1  outline-only mode; used only with FB_OUTLINE_EN.
- abort  in  1  cancel the current fill.
- write_address  out  ADDR_W  frame-buffer address.
- write_data  out  COLOR_W  pixel value.
- write_en  out  1  write request.
- wr_ready  in  1  write accepted this cycle.
- busy  out  1  engine not idle.
- done  out  1  one-cycle pulse when a fill completes.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - write_en=0, write_address=0, write_data=0, done=0, busy=0.
  - cmd_ready=1 as soon as Reset_n is high, since it is decoded from state==IDLE.
- Reset or abort mid-fill drops write_en immediately. No done pulse. Pixels already written stay written.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch all cmd_* fields and go to CLIP.
  - CLIP (1 cycle):
    - Compute x_end=min(x0+w,H_RES) and y_end=min(y0+h,V_RES) using 11-bit sums.
    - Empty command (w==0, h==0, x0>=H_RES or y0>=V_RES): go to DONE, zero writes.
    - Otherwise: x=x0, y=y0, row_base=y0*H_RES (one-time multiply allowed here), go to FILL.
  - FILL:
    - write_en=1, write_address=row_base+x, write_data=color.
    - Outputs hold stable while wr_ready=0.
    - On wr_ready: x++. When x+1==x_end, x=x0, y++, row_base+=H_RES (no per-pixel multiply).
    - Transfer of the pixel at (x_end-1, y_end-1) goes to DONE.
  - DONE (1 cycle): done=1, then IDLE.
- busy=1 in CLIP, FILL and DONE.
- abort has priority over wr_ready in every non-IDLE state: go to IDLE next cycle.
- Latency:
  - Command accepted in cycle N; first write_en in N+2.
  - With wr_ready held high, throughput is 1 pixel/cycle.
  - done asserts the cycle after the last accepted write.
- Commands offered while busy are not accepted. cmd_ready=0; the source holds its command.
- Clipping never wraps. Max address is 307199.

Optional Feature:
- Macro FB_OUTLINE_EN.
- When defined and cmd_outline=1: only perimeter pixels are written (y==y0 || y==y_end-1 || x==x0 || x==x_end-1).
  - Interior rows jump straight from x0 to x_end-1, giving 2 writes per interior row.
  - w==1 or h==1 degenerates to a full fill.
- When undefined, cmd_outline is ignored and every command is a solid fill.

Decomposition:
- Shared package fb_pkg:
  - H_RES, V_RES, FB_ADDR_W, COLOR_W constants.
  - typedef rgb332_t (packed r[2:0], g[2:0], b[1:0]).
  - typedef fb_cmd_t (x0, y0, w, h, color, outline).
  - enum fb_wr_state_t {IDLE, CLIP, FILL, DONE}.
- One sub-module fb_raster_counter: x/y counters, row_base accumulator, last-pixel flag. It is driven by an advance strobe and a load-from-command strobe. The FSM, clipping and handshakes stay in fb_rect_writer.

Test Plan:
- Basic fill: cmd (x0=10, y0=5, w=3, h=2, color=8'hE0), wr_ready=1.
  - Exactly 6 writes at addresses 3210, 3211, 3212, 3850, 3851, 3852, all data E0.
  - First write_en 2 cycles after accept; done 1 cycle after the last write.
- Clipping: cmd (x0=638, y0=479, w=5, h=4).
  - 2 writes at 307198 and 307199, then done.
- Empty command: (x0=700, y0=0, w=4, h=4) and separately (w=0).
  - No write_en; done 2 cycles after accept; cmd_ready back high the next cycle.
- Back-pressure: basic fill with wr_ready toggling 1,0,0,1,...
  - Address and data hold while stalled.
  - Same 6 addresses, no duplicates or skips.
- Abort/reset mid-fill: (0, 0, 100, 1).
  - Assert abort after 20 writes: write_en low the next cycle, no done, IDLE.
  - Repeat with a Reset_n pulse: outputs zero immediately.
- With FB_OUTLINE_EN: (x0=0, y0=0, w=4, h=3, outline=1).
  - Writes at 0, 1, 2, 3, 640, 643, 1280, 1281, 1282, 1283 only.
